alu_issue_arbiter: RTL and testbench
====================================

# alu_issue_arbiter

Round-robin issue arbiter that shares one fixed-latency pipelined ALU (2-bit opcode: 00 ADD, 01 SUB, 10 AND, 11 OR) among NREQ requesters. Each requester presents an op/operand pair with a valid/ready handshake. The block grants one requester per cycle and drives the ALU issue port with registered signals. It tracks the requester ID of every in-flight op through a tag pipeline matched to the ALU latency, then returns each result to its originator. It sits between the requester front-ends and the ALU pipeline.

## Interface
- WIDTH, 8, operand/result width in bits
- NREQ, 4, number of requesters (2..8)
- LAT, 2, ALU latency: alu_result is valid exactly LAT cycles after the cycle alu_issue is high (LAT >= 1)
- IDW, $clog2(NREQ), requester-ID width
- clk  input  1  sole clock; all logic on rising edge
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester grant; one-hot or zero
- req_op  input  2*NREQ  opcode, requester i at [2i+1:2i]
- req_src1  input  WIDTH*NREQ  operand 1, requester i at [WIDTH*i +: WIDTH]
- req_src2  input  WIDTH*NREQ  operand 2, same packing
- alu_issue  output  1  ALU issue strobe (registered)
- alu_op  output  2  opcode to ALU (registered)
- alu_src1  output  WIDTH  operand 1 to ALU (registered)
- alu_src2  output  WIDTH  operand 2 to ALU (registered)
- alu_result  input  WIDTH  ALU result; sampled only when a tag is due
- rsp_valid  output  NREQ  one-hot result strobe to originating requester (registered)
- rsp_id  output  IDW  requester ID of current response
- rsp_data  output  WIDTH  result data
- issue_count  output  16  total accepted requests since reset, wraps 0xFFFF->0

## Operation
- Arbitration is combinational on req_valid and the round-robin pointer rr_ptr (IDW bits). Grant goes to the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo NREQ.
- req_ready[grant]=1 only. All other bits are 0. All bits are 0 when no request is valid or reset=1.
- Handshake on requester i = req_valid[i] & req_ready[i]. Requesters hold op/operands stable while valid and unacknowledged. The arbiter never stalls, so there is no backpressure from the ALU or from the response side.
- On handshake with requester g, at the next edge:
  - alu_issue<=1
  - alu_op/alu_src1/alu_src2 <= requester g's fields
  - rr_ptr <= (g+1) mod NREQ
  - issue_count += 1
- Without a handshake, alu_issue<=0, alu_op/src hold their previous values, and rr_ptr is unchanged.
- Tag pipeline: LAT stages of {valid, id}. Stage 0 loads {alu_issue, issued id} each cycle and each stage shifts by one per cycle. The last stage is "due" when its valid bit is 1.
- When a tag is due: rsp_valid <= one-hot(id), rsp_id <= id, rsp_data <= alu_result. Otherwise rsp_valid <= 0, and rsp_id/rsp_data hold.
- No arithmetic is done here. ADD/SUB wrap modulo 2^WIDTH inside the ALU, and alu_result passes through unchanged.
- Responses stay in issue order. With one issue per cycle, at most one response per cycle is possible.

## Timing
- Reset (synchronous, edge with reset=1) clears:
  - rr_ptr=0, all tag valids=0, alu_issue=0
  - alu_op=0, alu_src1=0, alu_src2=0
  - rsp_valid=0, rsp_id=0, rsp_data=0
  - issue_count=0
- Latency:
  - handshake in cycle t -> alu_issue high in t+1
  - alu_result used in t+1+LAT
  - rsp_valid high in t+2+LAT (4 cycles for LAT=2)
- Throughput: one request per cycle, back-to-back. A single requester holding valid is granted every cycle.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,…,NREQ-1,0. No requester waits more than NREQ-1 cycles once valid.
- Simultaneous events: a new issue, a tag shift and a response retiring can all happen in the same cycle, and none blocks another.
- Reset mid-operation: in-flight tags are discarded and no rsp_valid is produced for them. Any alu_result arriving after reset is ignored. req_ready is 0 in every cycle reset is high.
- rr_ptr wraps from NREQ-1 to 0. For non-power-of-2 NREQ, pointer values >= NREQ never occur.

## Test plan
- Reset values: assert reset 2 cycles with all req_valid=1 -> req_ready=0 throughout; all outputs 0 after reset; issue_count=0.
- Single request:
  - Stimulus: requester 2 sends ADD 10,5 at cycle t.
  - Response: req_ready=4'b0100 at t; alu_issue=1 with op 00/10/5 at t+1; with a model ALU, rsp_valid=4'b0100, rsp_id=2, rsp_data=15 at t+4.
- Round-robin:
  - Stimulus: all 4 requesters hold valid (SUB 20,8 / AND 15,3 / OR 12,4 / ADD 255,1) for 8 cycles.
  - Response: grant order 0,1,2,3,0,1,2,3; responses 12,3,12,0 (ADD wraps) routed to IDs 0..3 in order; issue_count=8.
- Pointer skip:
  - Stimulus: after a grant to requester 0, only requester 0 and requester 3 are valid.
  - Response: requester 3 is granted next, then requester 0.
- Reset mid-flight:
  - Stimulus: issue 3 back-to-back ops, then assert reset at the cycle the first is due.
  - Response: zero rsp_valid pulses after reset; the next request is granted from rr_ptr=0.
- issue_count wrap: run 65537 handshakes -> issue_count=1.

Source files
------------

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter sharing one pipelined ALU among NREQ requesters.
// Tracks the originator of each in-flight op and routes its result back.
module alu_issue_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int LAT   = 2,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_src1,
  input  logic [WIDTH*NREQ-1:0] req_src2,
  output logic                  alu_issue,
  output logic [1:0]            alu_op,
  output logic [WIDTH-1:0]      alu_src1,
  output logic [WIDTH-1:0]      alu_src2,
  input  logic [WIDTH-1:0]      alu_result,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [15:0]           issue_count
);

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   alu_id;
  logic [IDW-1:0]   grant_id;
  logic             grant_any;
  logic             handshake;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_src1;
  logic [WIDTH-1:0] sel_src2;
  logic [LAT-1:0]   tag_v;
  logic [IDW-1:0]   tag_id [LAT];

  // Scan from the farthest offset down so the offset closest to rr_ptr wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && (((int'(rr_ptr) + k) % NREQ) == i)) begin
          grant_any = 1'b1;
          grant_id  = IDW'(i);
        end
      end
    end
    sel_op   = '0;
    sel_src1 = '0;
    sel_src2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(grant_id) == i) begin
        sel_op   = req_op[2*i +: 2];
        sel_src1 = req_src1[WIDTH*i +: WIDTH];
        sel_src2 = req_src2[WIDTH*i +: WIDTH];
      end
    end
  end

  assign handshake = grant_any & ~reset;
  assign req_ready = handshake ? (NREQ'(1) << grant_id) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= '0;
      alu_id      <= '0;
      alu_issue   <= 1'b0;
      alu_op      <= '0;
      alu_src1    <= '0;
      alu_src2    <= '0;
      tag_v       <= '0;
      for (int k = 0; k < LAT; k++) tag_id[k] <= '0;
      rsp_valid   <= '0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      issue_count <= '0;
    end else begin
      alu_issue <= handshake;
      if (handshake) begin
        alu_op      <= sel_op;
        alu_src1    <= sel_src1;
        alu_src2    <= sel_src2;
        alu_id      <= grant_id;
        rr_ptr      <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
        issue_count <= issue_count + 16'd1;
      end
      // Tag of the op on the issue port enters stage 0 as the ALU starts it.
      tag_v[0]  <= alu_issue;
      tag_id[0] <= alu_id;
      for (int k = 1; k < LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
      if (tag_v[LAT-1]) begin
        rsp_valid <= NREQ'(1) << tag_id[LAT-1];
        rsp_id    <= tag_id[LAT-1];
        rsp_data  <= alu_result;
      end else begin
        rsp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: table vectors, directed corner sequences and
// randomized traffic against a queue-based reference model with a model ALU.
module tb_alu_issue_arbiter;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int LAT   = 2;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_src1;
  logic [WIDTH*NREQ-1:0] req_src2;
  logic                  alu_issue;
  logic [1:0]            alu_op;
  logic [WIDTH-1:0]      alu_src1;
  logic [WIDTH-1:0]      alu_src2;
  logic [WIDTH-1:0]      alu_result;
  logic [NREQ-1:0]       rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic [15:0]           issue_count;

  logic [1:0]       op_a [NREQ];
  logic [WIDTH-1:0] s1_a [NREQ];
  logic [WIDTH-1:0] s2_a [NREQ];

  alu_issue_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2),
    .alu_issue(alu_issue), .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .issue_count(issue_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    req_op   = '0;
    req_src1 = '0;
    req_src2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_op[2*i +: 2]           = op_a[i];
      req_src1[WIDTH*i +: WIDTH] = s1_a[i];
      req_src2[WIDTH*i +: WIDTH] = s2_a[i];
    end
  end

  function automatic logic [WIDTH-1:0] alu_fn(input logic [1:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  // Model ALU: result appears LAT cycles after the issue cycle.
  logic [WIDTH-1:0] alu_pipe [LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_issue ? alu_fn(alu_op, alu_src1, alu_src2) : WIDTH'(8'hA5);
    for (int k = 1; k < LAT; k++) alu_pipe[k] <= alu_pipe[k-1];
  end
  assign alu_result = alu_pipe[LAT-1];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  typedef struct {
    int               due;
    int               id;
    logic [WIDTH-1:0] data;
  } rsp_t;
  rsp_t             rq [$];
  int               m_ptr = 0;
  logic [15:0]      m_count = '0;
  logic             m_issue = 1'b0;
  logic [1:0]       m_op = '0;
  logic [WIDTH-1:0] m_s1 = '0;
  logic [WIDTH-1:0] m_s2 = '0;
  int               m_rid = 0;
  logic [WIDTH-1:0] m_rdata = '0;
  int               last_grant = -1;

  task automatic step();
    int g;
    logic [NREQ-1:0] exp_rv;
    @(negedge clk);
    g = -1;
    if (!reset) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("alu_issue", 32'(alu_issue), 32'(m_issue));
    chk("alu_op",    32'(alu_op),    32'(m_op));
    chk("alu_src1",  32'(alu_src1),  32'(m_s1));
    chk("alu_src2",  32'(alu_src2),  32'(m_s2));
    exp_rv = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      exp_rv  = NREQ'(1) << rq[0].id;
      m_rid   = rq[0].id;
      m_rdata = rq[0].data;
      void'(rq.pop_front());
    end
    chk("rsp_valid",   32'(rsp_valid),   32'(exp_rv));
    chk("rsp_id",      32'(rsp_id),      32'(m_rid));
    chk("rsp_data",    32'(rsp_data),    32'(m_rdata));
    chk("issue_count", 32'(issue_count), 32'(m_count));
    last_grant = g;
    if (reset) begin
      m_ptr = 0; m_count = '0; m_issue = 1'b0;
      m_op = '0; m_s1 = '0; m_s2 = '0;
      m_rid = 0; m_rdata = '0;
      rq.delete();
    end else if (g >= 0) begin
      m_issue = 1'b1;
      m_op = op_a[g]; m_s1 = s1_a[g]; m_s2 = s2_a[g];
      m_ptr = (g + 1) % NREQ;
      m_count = m_count + 16'd1;
      rq.push_back('{due: cyc + 2 + LAT, id: g, data: alu_fn(op_a[g], s1_a[g], s2_a[g])});
    end else begin
      m_issue = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [NREQ-1:0]  valid;
    logic [NREQ-1:0]  ready;
    logic [NREQ-1:0]  rv;
    logic [WIDTH-1:0] rd;
  } vec_t;
  vec_t vt [16];

  initial begin
    int pulses;
    logic [NREQ-1:0]  rr_rv [4];
    logic [WIDTH-1:0] rr_rd [4];
    rr_rv = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rr_rd = '{8'd12, 8'd3, 8'd12, 8'd0};
    for (int i = 0; i < 16; i++) vt[i] = '{4'b0000, 4'b0000, 4'b0000, 8'd0};
    for (int i = 0; i < 8; i++) begin
      vt[i].valid = 4'b1111;
      vt[i].ready = 4'b0001 << (i % 4);
    end
    for (int i = 4; i < 12; i++) begin
      vt[i].rv = rr_rv[i % 4];
      vt[i].rd = rr_rd[i % 4];
    end
    vt[12] = '{4'b0001, 4'b0001, 4'b0000, 8'd0};
    vt[13] = '{4'b1001, 4'b1000, 4'b0000, 8'd0};
    vt[14] = '{4'b1001, 4'b0001, 4'b0000, 8'd0};

    for (int i = 0; i < NREQ; i++) begin op_a[i] = '0; s1_a[i] = '0; s2_a[i] = '0; end

    // Reset held for two cycles with every requester valid
    reset = 1'b1;
    req_valid = '1;
    @(negedge clk);
    chk("reset_ready0", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    cyc++;
    step();
    reset = 1'b0;
    req_valid = '0;
    step();

    // Single request: requester 2, ADD 10,5
    op_a[2] = 2'd0; s1_a[2] = 8'd10; s2_a[2] = 8'd5;
    req_valid = 4'b0100;
    #1 chk("single_ready", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    chk("single_issue", 32'(alu_issue), 32'd1);
    chk("single_op",    32'(alu_op),    32'd0);
    chk("single_src1",  32'(alu_src1),  32'd10);
    chk("single_src2",  32'(alu_src2),  32'd5);
    repeat (3) step();
    chk("single_rsp_valid", 32'(rsp_valid), 32'b0100);
    chk("single_rsp_id",    32'(rsp_id),    32'd2);
    chk("single_rsp_data",  32'(rsp_data),  32'd15);
    step();

    // Round-robin and pointer-skip table
    reset = 1'b1; step(); reset = 1'b0;
    op_a[0] = 2'd1; s1_a[0] = 8'd20;  s2_a[0] = 8'd8;
    op_a[1] = 2'd2; s1_a[1] = 8'd15;  s2_a[1] = 8'd3;
    op_a[2] = 2'd3; s1_a[2] = 8'd12;  s2_a[2] = 8'd4;
    op_a[3] = 2'd0; s1_a[3] = 8'd255; s2_a[3] = 8'd1;
    for (int i = 0; i < 16; i++) begin
      req_valid = vt[i].valid;
      #1;
      chk("tbl_ready",     32'(req_ready), 32'(vt[i].ready));
      chk("tbl_rsp_valid", 32'(rsp_valid), 32'(vt[i].rv));
      chk("tbl_rsp_data",  32'(rsp_data),  32'(vt[i].rd));
      if (i == 8) chk("rr_count", 32'(issue_count), 32'd8);
      step();
    end

    // Randomized traffic with occasional resets; unacked requests stay stable
    req_valid = '0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || last_grant == i) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          op_a[i] = 2'($urandom_range(0, 3));
          s1_a[i] = 8'($urandom_range(0, 255));
          s2_a[i] = 8'($urandom_range(0, 255));
        end
      end
      reset = ($urandom_range(0, 49) == 0);
      step();
    end
    reset = 1'b0;

    // Reset while three ops are in flight
    req_valid = '0;
    reset = 1'b1; step(); reset = 1'b0;
    step();
    req_valid = 4'b0010;
    repeat (3) step();
    req_valid = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid != '0) pulses++;
      step();
    end
    chk("midflight_pulses", 32'(pulses), 32'd0);
    req_valid = 4'b1010;
    #1 chk("midflight_regrant", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    repeat (5) step();

    // issue_count wrap
    reset = 1'b1; step(); reset = 1'b0;
    req_valid = 4'b0001;
    for (int i = 0; i < 65537; i++) step();
    req_valid = '0;
    chk("count_wrap", 32'(issue_count), 32'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
